dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one SRAM-like memory port between the instruction fetch requester
//   and the load/store (data) requester. At most one transaction is in flight.
//   Data normally has priority. A starvation counter lets a waiting fetch win
//   after four data grants have passed it.
//
// Ports
//   clk, reset         : clock and synchronous active-high reset
//   inst_*             : fetch request (read only) and its handshakes/response
//   data_*             : load/store request and its handshakes/response
//   mem_* (out)        : request fields driven onto the shared port
//   mem_addr_ok/
//   mem_data_ok/
//   mem_rdata (in)     : shared port responses
// -----------------------------------------------------------------------------
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic OWN_DATA = 1'b0;
  localparam logic OWN_INST = 1'b1;

  localparam logic [2:0] STARVE_MAX = 3'd4;

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic [2:0] starve_q, starve_d;

  logic in_idle;
  logic grant_inst;
  logic handshake;
  logic resp;

  // Arbitration and handshakes. Everything here is combinational so a grant
  // and its addr_ok land in the same cycle as the port accepts the request.
  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    // Fetch wins when it is alone, or when it has been passed over four times.
    grant_inst = inst_req & (~data_req | (starve_q == STARVE_MAX));
    // The synchronous reset only takes effect at the next edge, so it also
    // masks the request and response strobes while it is held.
    mem_req    = ~reset & in_idle & (inst_req | data_req);
    handshake  = mem_req & mem_addr_ok;
    // A response only counts while a transaction is outstanding; a stray
    // mem_data_ok in IDLE falls through here without effect.
    resp       = ~reset & ~in_idle & mem_data_ok;

    inst_addr_ok = handshake & grant_inst;
    data_addr_ok = handshake & ~grant_inst;
    inst_data_ok = resp & (owner_q == OWN_INST);
    data_data_ok = resp & (owner_q == OWN_DATA);

    inst_rdata = mem_rdata;
    data_rdata = mem_rdata;
  end

  // Request field mux from the granted requester. A fetch is always a
  // word-sized read with no byte enables.
  always_comb begin
    if (grant_inst) begin
      mem_wr    = 1'b0;
      mem_size  = 2'd2;
      mem_wstrb = 4'h0;
      mem_addr  = inst_addr;
      mem_wdata = 32'h0;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // Next-state logic.
  // NOTE: every *_d gets its hold value first so no path leaves it unassigned;
  // otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;

    if (handshake) begin
      state_d = ST_WAIT;
      owner_d = grant_inst ? OWN_INST : OWN_DATA;
      if (grant_inst) begin
        starve_d = 3'd0;
      end else if (inst_req && (starve_q < STARVE_MAX)) begin
        starve_d = starve_q + 3'd1;
      end
    end

    if (resp) begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_DATA;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. Directed cycle-by-cycle stimulus;
//   each accepted request pushes its expected response (owner, read data) to a
//   scoreboard queue, and the per-cycle monitor pops and compares whenever a
//   *_data_ok appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        is_inst;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pops the scoreboard whenever either requester sees a response.
  task automatic monitor();
    exp_t e;
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        check("unexpected_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_inst_data_ok", inst_data_ok, e.is_inst);
        check("resp_data_data_ok", data_data_ok, !e.is_inst);
        if (e.chk_rdata) begin
          check("resp_rdata", e.is_inst ? inst_rdata : data_rdata, e.rdata);
        end
      end
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; checks run 1 unit
  // later, well before the next edge.
  task automatic step();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  initial begin
    logic exp_inst;

    // ---------------- reset: strobes stay low while reset is held ----------
    quiet_inputs();
    reset       = 1'b1;
    inst_req    = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    quiet_inputs();
    #1;
    check("post_rst_mem_req", mem_req, 0);
    check("post_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();

    // ---------------- single fetch ------------------------------------------
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0000;
    mem_addr_ok = 1'b1;
    #1;
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h1C00_0000);
    check("f_inst_addr_ok", inst_addr_ok, 1);
    check("f_data_addr_ok", data_addr_ok, 0);
    check("f_mem_wr", mem_wr, 0);
    check("f_mem_size", mem_size, 2);
    check("f_mem_wstrb", mem_wstrb, 0);
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h0280_0400});
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    #1;
    check("f_wait_mem_req", mem_req, 0);
    check("f_wait_no_resp", {inst_data_ok, data_data_ok}, 0);
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0280_0400;
    #1;
    check("f_inst_data_ok", inst_data_ok, 1);
    check("f_data_data_ok", data_data_ok, 0);
    step();
    quiet_inputs();
    step();

    // ---------------- simultaneous fetch and load: data wins ---------------
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0004;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h0000_1000;
    mem_addr_ok = 1'b1;
    #1;
    check("c_mem_addr", mem_addr, 32'h0000_1000);
    check("c_data_addr_ok", data_addr_ok, 1);
    check("c_inst_addr_ok", inst_addr_ok, 0);
    sb.push_back(exp_t'{1'b0, 1'b1, 32'h1111_1111});
    step();
    data_req = 1'b0;
    #1;
    check("c_wait_mem_req", mem_req, 0);
    check("c_wait_inst_addr_ok", inst_addr_ok, 0);
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_1111;
    #1;
    check("c_data_data_ok", data_data_ok, 1);
    check("c_resp_no_new_req", mem_req, 0);
    check("c_resp_no_inst_ok", inst_addr_ok, 0);
    step();
    mem_data_ok = 1'b0;
    #1;
    check("c_inst_addr_ok_after", inst_addr_ok, 1);
    check("c_inst_mem_addr", mem_addr, 32'h1C00_0004);
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h2222_2222});
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h2222_2222;
    #1;
    check("c_inst_data_ok", inst_data_ok, 1);
    step();
    quiet_inputs();
    step();

    // ---------------- store word -------------------------------------------
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_size   = 2'd2;
    data_wstrb  = 4'hF;
    data_addr   = 32'h0000_2000;
    data_wdata  = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b1;
    #1;
    check("s_mem_wr", mem_wr, 1);
    check("s_mem_wstrb", mem_wstrb, 4'hF);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("s_mem_addr", mem_addr, 32'h0000_2000);
    check("s_mem_size", mem_size, 2);
    check("s_data_addr_ok", data_addr_ok, 1);
    sb.push_back(exp_t'{1'b0, 1'b0, 32'h0});
    step();
    quiet_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5A5A_5A5A;
    #1;
    check("s_data_data_ok", data_data_ok, 1);
    step();
    quiet_inputs();
    step();

    // ---------------- port stalls: request held stable ----------------------
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd1;
    data_wstrb = 4'h3;
    data_addr  = 32'h0000_3002;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_mem_req", mem_req, 1);
      check("st_mem_addr", mem_addr, 32'h0000_3002);
      check("st_mem_size", mem_size, 1);
      check("st_addr_oks", {inst_addr_ok, data_addr_ok}, 0);
      step();
    end
    mem_addr_ok = 1'b1;
    #1;
    check("st_data_addr_ok", data_addr_ok, 1);
    sb.push_back(exp_t'{1'b0, 1'b1, 32'h3333_4444});
    step();
    quiet_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3333_4444;
    step();
    quiet_inputs();

    // Withdrawn fetch before acceptance, then a stray response in IDLE:
    // neither may produce a transaction or a response.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0008;
    step();
    inst_req    = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    check("idle_stray_mem_req", mem_req, 0);
    check("idle_stray_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();
    quiet_inputs();
    step();

    // ---------------- starvation: 4 data grants, then 1 fetch --------------
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0100;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h0000_4000;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    for (int t = 0; t < 10; t++) begin
      exp_inst  = ((t % 5) == 4);
      mem_rdata = 32'hBAD0_0000;
      #1;
      check("arb_inst_addr_ok", inst_addr_ok, exp_inst);
      check("arb_data_addr_ok", data_addr_ok, !exp_inst);
      check("arb_mem_addr", mem_addr, exp_inst ? 32'h1C00_0100 : 32'h0000_4000);
      sb.push_back(exp_t'{exp_inst, 1'b1, 32'hA500_0000 + 32'(t)});
      step();
      mem_rdata = 32'hA500_0000 + 32'(t);
      #1;
      check("arb_wait_mem_req", mem_req, 0);
      step();
    end
    quiet_inputs();
    step();

    // ---------------- reset while a transaction is outstanding --------------
    data_req    = 1'b1;
    data_addr   = 32'h0000_5000;
    mem_addr_ok = 1'b1;
    #1;
    check("rw_data_addr_ok", data_addr_ok, 1);
    step();
    quiet_inputs();
    reset       = 1'b1;
    mem_data_ok = 1'b1;
    #1;
    check("rw_in_reset_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();
    reset = 1'b0;
    #1;
    check("rw_spurious_data_ok", {inst_data_ok, data_data_ok}, 0);
    step();
    #1;
    check("rw_spurious_data_ok2", {inst_data_ok, data_data_ok}, 0);
    step();
    quiet_inputs();
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0200;
    mem_addr_ok = 1'b1;
    #1;
    check("rw_inst_addr_ok", inst_addr_ok, 1);
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h0C0F_FEE0});
    step();
    quiet_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0C0F_FEE0;
    #1;
    check("rw_inst_data_ok", inst_data_ok, 1);
    step();
    quiet_inputs();
    step();

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
